// File: rtl/qmem_pkg.sv
`default_nettype none
// ============================================================================
// qmem_pkg : shared QMEM widths, arbiter state encoding, packed-slice helper
// Rev 1.0
// ============================================================================
package qmem_pkg;

    localparam int QAW_DEF = 22;
    localparam int QDW_DEF = 32;
    localparam int QSW_DEF = QDW_DEF / 8;

    // Helper limits: packed master vectors up to 1024 bits, fields up to 64 bits
    localparam int SLICE_MAXW = 1024;
    localparam int SLICE_MAXF = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    function automatic logic [SLICE_MAXF-1:0] get_slice(
        input logic [SLICE_MAXW-1:0] vec,
        input int unsigned           idx,
        input int unsigned           w
    );
        logic [SLICE_MAXW-1:0] sh;
        logic [SLICE_MAXF-1:0] mask;
        sh   = vec >> (idx * w);
        mask = (w >= SLICE_MAXF) ? '1 : ((SLICE_MAXF'(1) << w) - SLICE_MAXF'(1));
        return sh[SLICE_MAXF-1:0] & mask;
    endfunction

endpackage : qmem_pkg
`default_nettype wire

// File: rtl/qmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// qmem_arbiter_if : QN QMEM masters plus one QMEM slave port, arbiter view
// Rev 1.0
// ============================================================================
interface qmem_arbiter_if #(
    parameter int QN  = 3,
    parameter int QAW = 22,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8
);
    logic [QN-1:0]     m_cs;
    logic [QN-1:0]     m_we;
    logic [QN*QSW-1:0] m_sel;
    logic [QN*QAW-1:0] m_adr;
    logic [QN*QDW-1:0] m_dat_w;
    logic [QDW-1:0]    m_dat_r;
    logic [QN-1:0]     m_ack;
    logic [QN-1:0]     m_err;

    logic              s_cs;
    logic              s_we;
    logic [QSW-1:0]    s_sel;
    logic [QAW-1:0]    s_adr;
    logic [QDW-1:0]    s_dat_w;
    logic [QDW-1:0]    s_dat_r;
    logic              s_ack;
    logic              s_err;

    modport arb (
        input  m_cs, m_we, m_sel, m_adr, m_dat_w, s_dat_r, s_ack, s_err,
        output m_dat_r, m_ack, m_err, s_cs, s_we, s_sel, s_adr, s_dat_w
    );

    modport master (
        output m_cs, m_we, m_sel, m_adr, m_dat_w,
        input  m_dat_r, m_ack, m_err
    );

    modport slave (
        input  s_cs, s_we, s_sel, s_adr, s_dat_w,
        output s_dat_r, s_ack, s_err
    );

endinterface : qmem_arbiter_if
`default_nettype wire

// File: rtl/qmem_rr_pick.sv
`default_nettype none
// ============================================================================
// qmem_rr_pick : combinational round-robin / fixed-priority one-hot picker
// Rev 1.0
// ============================================================================
module qmem_rr_pick #(
    parameter int QN = 3,
    parameter int PW = $clog2(QN)
) (
    input  logic [QN-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          fixed_i,
    output logic [QN-1:0] win_o
);

    logic [PW-1:0] w_eff_ptr;
    logic [QN-1:0] w_rot;

    assign w_eff_ptr = fixed_i ? '0 : ptr_i;
    // Doubling the request vector turns the wrap-around into a plain shift
    assign w_rot     = QN'({req_i, req_i} >> w_eff_ptr);

    always_comb begin
        logic found;
        int   pos;
        win_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < QN; k++) begin
            if (!found && w_rot[k]) begin
                found = 1'b1;
                pos   = k + int'(w_eff_ptr);
                if (pos >= QN) pos = pos - QN;
                win_o = QN'(1) << pos;
            end
        end
    end

endmodule : qmem_rr_pick
`default_nettype wire

// File: rtl/qmem_arbiter.sv
`default_nettype none
// ============================================================================
// qmem_arbiter : shares one QMEM slave port between QN masters, one grant per txn
// Rev 1.0
// ============================================================================
module qmem_arbiter
    import qmem_pkg::*;
#(
    parameter int QN         = 3,
    parameter int QAW        = QAW_DEF,
    parameter int QDW        = QDW_DEF,
    parameter int QSW        = QDW / 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    qmem_arbiter_if.arb   bus,
    output logic [QN-1:0] grant,
    output logic          busy
);

    localparam int PW = $clog2(QN);

    logic [QN-1:0] grant_q, grant_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [QN-1:0] w_win;
    logic [PW-1:0] w_win_idx;
    logic          w_own_cs;
    logic          w_owned;
    arb_state_e    w_state;

    qmem_rr_pick #(
        .QN (QN),
        .PW (PW)
    ) u_pick (
        .req_i   (bus.m_cs),
        .ptr_i   (ptr_q),
        .fixed_i (FIXED_PRIO != 0),
        .win_o   (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < QN; i++) begin
            if (w_win[i]) w_win_idx = PW'(i);
        end
    end

    assign w_owned  = |grant_q;
    assign w_state  = w_owned ? ST_OWNED : ST_IDLE;
    assign w_own_cs = |(bus.m_cs & grant_q);

    // Arbitration only in IDLE; any ack, err or owner dropping cs ends ownership
    always_comb begin
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (w_state)
            ST_IDLE: begin
                if (|bus.m_cs) begin
                    grant_d = w_win;
                    idx_d   = w_win_idx;
                    if (FIXED_PRIO == 0) begin
                        ptr_d = (w_win_idx == PW'(QN - 1)) ? '0 : w_win_idx + PW'(1);
                    end
                end
            end
            ST_OWNED: begin
                if (bus.s_ack || bus.s_err || !w_own_cs) grant_d = '0;
            end
            default: grant_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Slave side: everything gated by the registered grant
    assign bus.s_cs    = w_own_cs;
    assign bus.s_we    = |(bus.m_we & grant_q);
    assign bus.s_sel   = w_owned ? QSW'(get_slice(SLICE_MAXW'(bus.m_sel),   32'(idx_q), QSW)) : '0;
    assign bus.s_adr   = w_owned ? QAW'(get_slice(SLICE_MAXW'(bus.m_adr),   32'(idx_q), QAW)) : '0;
    assign bus.s_dat_w = w_owned ? QDW'(get_slice(SLICE_MAXW'(bus.m_dat_w), 32'(idx_q), QDW)) : '0;

    assign bus.m_dat_r = bus.s_dat_r;
    assign bus.m_ack   = grant_q & {QN{bus.s_ack}};
    assign bus.m_err   = grant_q & {QN{bus.s_err}};

    assign grant = grant_q;
    assign busy  = w_owned;

endmodule : qmem_arbiter
`default_nettype wire
